mem_stage: RTL
==============

# mem_stage

Memory-stage pipeline block of the N-bit NARK datapath, directly downstream of the execute-stage condition unit. It registers the condition-qualified execute results (PCSrc, RegWrite, MemWrite) together with the ALU result and store data into the E/M register. It runs the data-memory request/acknowledge handshake with a timeout and stalls the front of the pipe while memory is busy. It then produces the M/W register that feeds writeback, plus the M-stage forwarding taps.

## Interface
- N, 32, datapath width
- TIMEOUT, 16, maximum WAIT cycles before a memory access is aborted (≥2)

- CLK  in  1  clock, rising edge
- Reset  in  1  synchronous, active-high
- PCSrcC, RegWriteC, MemWriteC  in  1 each  condition-qualified controls from the condition unit
- MemtoRegE  in  1  load select from execute
- ALUResultE  in  N  ALU result / address
- WriteDataE  in  N  store data
- WA3E  in  4  destination register
- FlushM  in  1  load a bubble into E/M
- MemReq  out  1  memory request
- MemWe  out  1  1 = store, 0 = load
- MemAddr, MemWData  out  N  memory address / store data
- MemRData  in  N  load data, valid when MemAck=1
- MemAck  in  1  access complete this cycle
- StallM  out  1  hold F/D/E registers and the condition unit's flag register
- ALUOutM, WA3M, RegWriteM  out  N/4/1  forwarding taps (E/M register contents)
- RegWriteW, MemtoRegW, PCSrcW  out  1 each  M/W controls
- ReadDataW, ALUOutW  out  N  M/W data
- WA3W  out  4  M/W destination
- MemErr  out  1  sticky timeout flag

## Operation
- E/M register (PCSrc, RegWrite, MemWrite, MemtoReg, ALUOut, WriteData, WA3): loads when StallM=0; loads zeros when FlushM=1 and StallM=0; holds when StallM=1. FlushM is ignored while StallM=1.
- Memory op pending: memop = MemWriteM | (MemtoRegM & RegWriteM). A predicated-off load is not issued.
- MemReq = memop & (state==IDLE or state==WAIT).
- MemWe = MemWriteM, MemAddr = ALUOutM, MemWData = WriteDataM. All are driven straight from the E/M register, so they are stable for the whole request.
- FSM mem_state_t {IDLE, WAIT}:
  - IDLE, memop=0: no request, StallM=0.
  - IDLE, memop=1, MemAck=1: zero-wait completion, StallM=0, stay in IDLE.
  - IDLE, memop=1, MemAck=0: StallM=1, go to WAIT, wait counter cleared.
  - WAIT, MemAck=1: complete, StallM=0, go to IDLE.
  - WAIT, MemAck=0: StallM=1, counter +1. When the counter reaches TIMEOUT-1: abort, StallM=0, MemErr←1, go to IDLE, instruction retires as a bubble.
- M/W register: loads E/M fields plus ReadDataW←MemRData when StallM=0. RegWriteW and PCSrcW are forced to 0 while StallM=1 (bubble, no double write) and on an aborted access.
- MemErr is cleared only by Reset.
- Counter width is $clog2(TIMEOUT). It never wraps; it saturates at abort.

## Timing
- Reset edge: state IDLE; counter 0; every register output 0; MemErr 0. MemReq and StallM are 0 in the following cycle.
- Reset asserted during WAIT: the access is abandoned, no W write. A late MemAck after reset is ignored because memop=0.
- Latency with zero-wait memory: an instruction in E at cycle t is in M at t+1 and in W at t+2.
- With k wait cycles the instruction reaches W at t+2+k. StallM is high for exactly k cycles.
- MemAck while MemReq=0 is ignored.
- MemAck in the same cycle as the timeout boundary counts as a completion; the ack wins.

## Structure
- nark_pkg holds mem_state_t and the default N. The counter width is derived locally from TIMEOUT.
- One sub-module, mem_handshake_fsm: state, counter, StallM, abort and MemErr.
- E/M and M/W registers reuse the existing enabled FlipFlop register.

## Test plan
- Zero-wait ALU op: ALUResultE=0x10, WA3E=3, RegWriteC=1, MemAck tied 1 → two cycles later RegWriteW=1, ALUOutW=0x10, WA3W=3, StallM never asserted.
- Load, 3 wait cycles: ALUResultE=0x40, MemtoRegE=1, RegWriteC=1; MemAck=1 with MemRData=0xDEAD on the 4th request cycle → StallM=1 for 3 cycles, MemAddr=0x40 stable, a single W write with ReadDataW=0xDEAD.
- Predicated-off store: MemWriteC=0 (CondEx false) → MemReq stays 0, no stall.
- Timeout: store issued, MemAck held 0 → StallM=1 for TIMEOUT-1 cycles, then MemErr=1, StallM=0, RegWriteW=0; a later Reset clears MemErr.
- FlushM during a stall → ignored. FlushM with StallM=0 → next-cycle RegWriteM=0 and no MemReq.
- Reset in WAIT after 2 cycles → next cycle MemReq=0, StallM=0, all W outputs 0; a MemAck pulse afterwards causes no W write.

Source files
------------

// File: rtl/nark_pkg.sv
// Shared NARK datapath types for the memory stage.
package nark_pkg;

  localparam int N_DEFAULT = 32;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the M stage and data memory.
interface mem_stage_if #(parameter int N = nark_pkg::N_DEFAULT);

  logic         MemReq;
  logic         MemWe;
  logic [N-1:0] MemAddr;
  logic [N-1:0] MemWData;
  logic [N-1:0] MemRData;
  logic         MemAck;

  modport master (
    output MemReq, MemWe, MemAddr, MemWData,
    input  MemRData, MemAck
  );

  modport slave (
    input  MemReq, MemWe, MemAddr, MemWData,
    output MemRData, MemAck
  );

endinterface

// File: rtl/FlipFlop.sv
// Generic enabled register with synchronous active-high reset.
module FlipFlop #(
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             En,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  always_ff @(posedge CLK) begin
    if (Reset)   Q <= '0;
    else if (En) Q <= D;
  end

endmodule

// File: rtl/mem_handshake_fsm.sv
// Memory handshake controller: request qualification, wait counting, timeout abort.
//   state | meaning
//   IDLE  | no access outstanding; a new access either completes now or starts waiting
//   WAIT  | access outstanding, pipe stalled until ack or timeout
module mem_handshake_fsm
  import nark_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic CLK,
  input  logic Reset,
  input  logic memOp,
  input  logic memAck,
  output logic memReq,
  output logic stallM,
  output logic abort,
  output logic memErr
);

  localparam int CW = $clog2(TIMEOUT);
  // Abort fires on the WAIT cycle whose increment would reach TIMEOUT-1.
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 2);

  mem_state_t    state, nextState;
  logic [CW-1:0] waitCnt, nextCnt;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state   <= IDLE;
      waitCnt <= '0;
      memErr  <= 1'b0;
    end else begin
      state   <= nextState;
      waitCnt <= nextCnt;
      if (abort) memErr <= 1'b1;
    end
  end

  always_comb begin
    nextState = state;
    nextCnt   = waitCnt;
    stallM    = 1'b0;
    abort     = 1'b0;
    memReq    = memOp & ((state == IDLE) | (state == WAIT));
    case (state)
      IDLE: begin
        if (memOp && !memAck) begin
          stallM    = 1'b1;
          nextState = WAIT;
          nextCnt   = '0;
        end
      end
      WAIT: begin
        if (memAck) begin
          nextState = IDLE;
        end else begin
          nextCnt = waitCnt + 1'b1;
          if (waitCnt == LAST_CNT) begin
            abort     = 1'b1;
            nextState = IDLE;
          end else begin
            stallM = 1'b1;
          end
        end
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// NARK memory stage: E/M register, data-memory handshake, M/W register and M forwarding taps.
module mem_stage
  import nark_pkg::*;
#(
  parameter int N       = N_DEFAULT,
  parameter int TIMEOUT = 16
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         PCSrcC,
  input  logic         RegWriteC,
  input  logic         MemWriteC,
  input  logic         MemtoRegE,
  input  logic [N-1:0] ALUResultE,
  input  logic [N-1:0] WriteDataE,
  input  logic [3:0]   WA3E,
  input  logic         FlushM,
  mem_stage_if.master  memBus,
  output logic         StallM,
  output logic [N-1:0] ALUOutM,
  output logic [3:0]   WA3M,
  output logic         RegWriteM,
  output logic         RegWriteW,
  output logic         MemtoRegW,
  output logic         PCSrcW,
  output logic [N-1:0] ReadDataW,
  output logic [N-1:0] ALUOutW,
  output logic [3:0]   WA3W,
  output logic         MemErr
);

  localparam int EM_W   = 4 + 2 * N + 4;
  localparam int MW_W   = 1 + 2 * N + 4;

  logic            PCSrcM, MemWriteM, MemtoRegM;
  logic [N-1:0]    WriteDataM;
  logic [EM_W-1:0] emD, emQ;
  logic [MW_W-1:0] mwD, mwQ;
  logic [1:0]      mwCtlD, mwCtlQ;
  logic            memOp, abort;

  assign emD = FlushM ? '0 : {PCSrcC, RegWriteC, MemWriteC, MemtoRegE, ALUResultE, WriteDataE, WA3E};

  FlipFlop #(.WIDTH(EM_W)) emReg (
    .CLK(CLK), .Reset(Reset), .En(~StallM), .D(emD), .Q(emQ)
  );

  assign {PCSrcM, RegWriteM, MemWriteM, MemtoRegM, ALUOutM, WriteDataM, WA3M} = emQ;

  // A predicated-off load never reaches memory.
  assign memOp = MemWriteM | (MemtoRegM & RegWriteM);

  mem_handshake_fsm #(.TIMEOUT(TIMEOUT)) handshake (
    .CLK(CLK),
    .Reset(Reset),
    .memOp(memOp),
    .memAck(memBus.MemAck),
    .memReq(memBus.MemReq),
    .stallM(StallM),
    .abort(abort),
    .memErr(MemErr)
  );

  assign memBus.MemWe    = MemWriteM;
  assign memBus.MemAddr  = ALUOutM;
  assign memBus.MemWData = WriteDataM;

  assign mwD = {MemtoRegM, memBus.MemRData, ALUOutM, WA3M};

  FlipFlop #(.WIDTH(MW_W)) mwDataReg (
    .CLK(CLK), .Reset(Reset), .En(~StallM), .D(mwD), .Q(mwQ)
  );

  // Controls load every cycle so stalls and aborts turn into bubbles, never repeat writes.
  assign mwCtlD = (StallM | abort) ? 2'b00 : {RegWriteM, PCSrcM};

  FlipFlop #(.WIDTH(2)) mwCtlReg (
    .CLK(CLK), .Reset(Reset), .En(1'b1), .D(mwCtlD), .Q(mwCtlQ)
  );

  assign {MemtoRegW, ReadDataW, ALUOutW, WA3W} = mwQ;
  assign {RegWriteW, PCSrcW} = mwCtlQ;

endmodule
